// File: rtl/el2_lsu_fault_pipe.sv
// LSU fault staging pipe: carries D-stage address-check faults through M and R,
// presents the R-stage error packet, and keeps a sticky first-fault record with
// a saturating count of faults lost while the record was occupied.
module el2_lsu_fault_pipe #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned CAUSE_W = 4,
    parameter int unsigned DROP_W  = 8
) (
    input  logic               i_lsu_c2_m_clk,
    input  logic               i_rst,
    input  logic               i_pkt_valid_d,
    input  logic               i_pkt_store_d,
    input  logic               i_pkt_dma_d,
    input  logic               i_pkt_fast_int_d,
    input  logic               i_access_fault_d,
    input  logic               i_misaligned_fault_d,
    input  logic [CAUSE_W-1:0] i_exc_mscause_d,
    input  logic [ADDR_W-1:0]  i_start_addr_d,
    input  logic               i_fir_dccm_err_d,
    input  logic               i_fir_nondccm_err_d,
    input  logic               i_flush_r,
    input  logic               i_capt_ack,
    output logic               o_error_valid_r,
    output logic               o_error_store_r,
    output logic               o_error_exc_type_r,
    output logic [CAUSE_W-1:0] o_error_mscause_r,
    output logic [ADDR_W-1:0]  o_error_addr_r,
    output logic [1:0]         o_fir_err_r,
    output logic               o_capt_valid,
    output logic               o_capt_store,
    output logic               o_capt_exc_type,
    output logic [CAUSE_W-1:0] o_capt_mscause,
    output logic [ADDR_W-1:0]  o_capt_addr,
    output logic [DROP_W-1:0]  o_drop_cnt
);

    localparam logic [DROP_W-1:0] DropOne = DROP_W'(1);

    // D-stage qualification
    logic         w_fault_d;
    logic         w_exc_type_d;
    logic [1:0]   w_fir_d;
    logic         w_keep;
    logic         w_free;
    logic         w_drop_sat;

    // M stage
    logic               r_valid_m;
    logic               r_store_m;
    logic               r_exc_type_m;
    logic [CAUSE_W-1:0] r_mscause_m;
    logic [ADDR_W-1:0]  r_addr_m;
    logic [1:0]         r_fir_m;

    // R stage
    logic               r_valid_r;
    logic               r_store_r;
    logic               r_exc_type_r;
    logic [CAUSE_W-1:0] r_mscause_r;
    logic [ADDR_W-1:0]  r_addr_r;
    logic [1:0]         r_fir_r;

    // Capture record
    logic               r_capt_valid;
    logic               r_capt_store;
    logic               r_capt_exc_type;
    logic [CAUSE_W-1:0] r_capt_mscause;
    logic [ADDR_W-1:0]  r_capt_addr;
    logic [DROP_W-1:0]  r_drop_cnt;

    // DMA never faults; misaligned takes priority over access
    assign w_fault_d    = i_pkt_valid_d & ~i_pkt_dma_d & (i_access_fault_d | i_misaligned_fault_d);
    assign w_exc_type_d = ~i_misaligned_fault_d;
    assign w_fir_d      = {i_fir_nondccm_err_d, i_fir_dccm_err_d} &
                          {2{i_pkt_valid_d & i_pkt_fast_int_d}};
    assign w_keep       = ~i_flush_r;
    // An ack frees the record for a fault arriving on the same edge
    assign w_free       = ~r_capt_valid | i_capt_ack;
    assign w_drop_sat   = &r_drop_cnt;

    // M stage: advances every clock; flush clears only valid/fir bits
    always_ff @(posedge i_lsu_c2_m_clk) begin
        if (i_rst) begin
            r_valid_m    <= 1'b0;
            r_store_m    <= 1'b0;
            r_exc_type_m <= 1'b0;
            r_mscause_m  <= '0;
            r_addr_m     <= '0;
            r_fir_m      <= 2'b00;
        end else begin
            r_valid_m    <= w_fault_d & w_keep;
            r_store_m    <= i_pkt_store_d;
            r_exc_type_m <= w_exc_type_d;
            r_mscause_m  <= i_exc_mscause_d;
            r_addr_m     <= i_start_addr_d;
            r_fir_m      <= w_fir_d & {2{w_keep}};
        end
    end

    // R stage: follows M every clock; flush clears only valid/fir bits
    always_ff @(posedge i_lsu_c2_m_clk) begin
        if (i_rst) begin
            r_valid_r    <= 1'b0;
            r_store_r    <= 1'b0;
            r_exc_type_r <= 1'b0;
            r_mscause_r  <= '0;
            r_addr_r     <= '0;
            r_fir_r      <= 2'b00;
        end else begin
            r_valid_r    <= r_valid_m & w_keep;
            r_store_r    <= r_store_m;
            r_exc_type_r <= r_exc_type_m;
            r_mscause_r  <= r_mscause_m;
            r_addr_r     <= r_addr_m;
            r_fir_r      <= r_fir_m & {2{w_keep}};
        end
    end

    // Sticky first-fault record and saturating dropped-fault counter
    always_ff @(posedge i_lsu_c2_m_clk) begin
        if (i_rst) begin
            r_capt_valid    <= 1'b0;
            r_capt_store    <= 1'b0;
            r_capt_exc_type <= 1'b0;
            r_capt_mscause  <= '0;
            r_capt_addr     <= '0;
            r_drop_cnt      <= '0;
        end else begin
            if (r_valid_r & w_free) begin
                r_capt_valid    <= 1'b1;
                r_capt_store    <= r_store_r;
                r_capt_exc_type <= r_exc_type_r;
                r_capt_mscause  <= r_mscause_r;
                r_capt_addr     <= r_addr_r;
            end else if (i_capt_ack) begin
                // Fields are held so the TLU may still read them after ack
                r_capt_valid <= 1'b0;
            end

            if (i_capt_ack) begin
                r_drop_cnt <= '0;
            end else if (r_valid_r & r_capt_valid & ~w_drop_sat) begin
                r_drop_cnt <= r_drop_cnt + DropOne;
            end
        end
    end

    assign o_error_valid_r    = r_valid_r;
    assign o_error_store_r    = r_store_r;
    assign o_error_exc_type_r = r_exc_type_r;
    assign o_error_mscause_r  = r_mscause_r;
    assign o_error_addr_r     = r_addr_r;
    assign o_fir_err_r        = r_fir_r;
    assign o_capt_valid       = r_capt_valid;
    assign o_capt_store       = r_capt_store;
    assign o_capt_exc_type    = r_capt_exc_type;
    assign o_capt_mscause     = r_capt_mscause;
    assign o_capt_addr        = r_capt_addr;
    assign o_drop_cnt         = r_drop_cnt;

endmodule
